mcp3008_scanner: RTL and testbench

MCP3008_SCANNER -- requirements
Module: mcp3008_scanner

---
 rtl/mcp3008_pkg.sv | 45 ++++
 rtl/mcp3008_scanner_if.sv | 27 ++
 rtl/mcp3008_sclk_gen.sv | 29 ++
 rtl/mcp3008_scanner.sv | 166 ++++++++++++++++
 tb/tb_mcp3008_scanner.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcp3008_pkg.sv
// Shared types, frame constants and channel-search helpers for the MCP3008 scanner.
package mcp3008_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StFrame,
        StGap
    } state_e;

    localparam int unsigned FRAME_HALVES    = 35;
    localparam int unsigned NUM_CH          = 8;
    localparam int unsigned ADC_BITS        = 10;
    localparam int unsigned FIRST_DATA_EDGE = 8;
    localparam int unsigned CMD_BITS        = 5;

    typedef logic [$clog2(NUM_CH)-1:0] ch_idx_t;

    // First set mask bit at or above start, wrapping past the top channel.
    function automatic ch_idx_t next_ch(input logic [NUM_CH-1:0] mask, input ch_idx_t start);
        ch_idx_t r;
        ch_idx_t c;
        r = start;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            c = start + ch_idx_t'(i);
            if (mask[c]) begin
                r = c;
            end
        end
        return r;
    endfunction

    // Highest set mask bit; marks the last channel of a scan pass.
    function automatic ch_idx_t highest_ch(input logic [NUM_CH-1:0] mask);
        ch_idx_t r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (mask[i]) begin
                r = ch_idx_t'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mcp3008_scanner_if.sv
// Control, SPI and result signals of the MCP3008 scanner.
interface mcp3008_scanner_if;
    import mcp3008_pkg::*;

    logic                               enable;
    logic [NUM_CH-1:0]                  ch_mask;
    logic                               AD_CLK;
    logic                               CS;
    logic                               DIN;
    logic                               DOUT;
    logic [ADC_BITS-1:0]                sample_data;
    logic [2:0]                         sample_ch;
    logic                               sample_valid;
    logic [NUM_CH-1:0][ADC_BITS-1:0]    analog_scan;
    logic                               scan_done;

    modport master (
        input  enable, ch_mask, DOUT,
        output AD_CLK, CS, DIN, sample_data, sample_ch, sample_valid, analog_scan, scan_done
    );

    modport slave (
        output enable, ch_mask, DOUT,
        input  AD_CLK, CS, DIN, sample_data, sample_ch, sample_valid, analog_scan, scan_done
    );

endinterface

// File: rtl/mcp3008_sclk_gen.sv
// Clock-enable divider: one-clk tick at the end of every ad_clk half-period while running.
module mcp3008_sclk_gen #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic tick_o
);

    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LastCnt = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Count clks within a half-period; held at zero when idle so a frame starts phase-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!run_i || cnt_q == LastCnt) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick_o = run_i && (cnt_q == LastCnt);

endmodule

// File: rtl/mcp3008_scanner.sv
// Continuous round-robin scanner for an MCP3008 ADC over SPI mode 0,0.
module mcp3008_scanner
    import mcp3008_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 25,
    parameter int unsigned CS_IDLE_HALF = 2,
    parameter logic        SGL          = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    mcp3008_scanner_if.master  bus
);

    localparam int unsigned HalfMax = (FRAME_HALVES > CS_IDLE_HALF) ? FRAME_HALVES : CS_IDLE_HALF;
    localparam int unsigned HW      = $clog2(HalfMax + 1);

    localparam logic [HW-1:0] LastHalf      = HW'(FRAME_HALVES - 1);
    localparam logic [HW-1:0] LastGap       = HW'(CS_IDLE_HALF - 1);
    localparam logic [HW-1:0] CmdHalves     = HW'(2 * CMD_BITS);
    localparam logic [HW-1:0] FirstDataHalf = HW'(2 * FIRST_DATA_EDGE - 1);

    state_e                          state_q;
    logic [HW-1:0]                   half_q;
    ch_idx_t                         ch_q;
    ch_idx_t                         start_q;
    logic [ADC_BITS-1:0]             sh_q;
    logic                            cs_q;
    logic                            adclk_q;
    logic                            din_q;
    logic                            valid_q;
    logic                            done_q;
    logic [ADC_BITS-1:0]             data_q;
    ch_idx_t                         sch_q;
    logic [NUM_CH-1:0][ADC_BITS-1:0] scan_q;

    logic                            run;
    logic                            tick;
    logic [HW-1:0]                   nh;
    logic [CMD_BITS-1:0]             cmd_rev;
    logic                            din_next;
    logic                            sample_en;
    ch_idx_t                         sel_ch;
    ch_idx_t                         hi_ch;

    assign run = (state_q != StIdle);

    mcp3008_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst    (rst),
        .run_i  (run),
        .tick_o (tick)
    );

    // Decode of the upcoming half: command bit, data-sample slot and channel search.
    always_comb begin
        nh        = half_q + HW'(1);
        // Command bit i is start, SGL, D2, D1, D0 for i = 0..4.
        cmd_rev   = {ch_q[0], ch_q[1], ch_q[2], SGL, 1'b1};
        din_next  = 1'b0;
        if (nh < CmdHalves) begin
            din_next = cmd_rev[nh[3:1]];
        end
        // Odd halves 15..33 are the rising edges that carry B9..B0.
        sample_en = nh[0] && (nh >= FirstDataHalf) && (nh < LastHalf);
        sel_ch    = next_ch(bus.ch_mask, start_q);
        hi_ch     = highest_ch(bus.ch_mask);
    end

    // Frame sequencer with all SPI pins and results registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            half_q  <= '0;
            ch_q    <= '0;
            start_q <= '0;
            sh_q    <= '0;
            cs_q    <= 1'b1;
            adclk_q <= 1'b0;
            din_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            sch_q   <= '0;
            scan_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.enable && (bus.ch_mask != '0)) begin
                        // CS falls with SELECT so SELECT counts as the first clk of half 0.
                        state_q <= StSelect;
                        cs_q    <= 1'b0;
                        din_q   <= 1'b1;
                    end
                end
                StSelect: begin
                    if (bus.ch_mask != '0) begin
                        state_q <= StFrame;
                        ch_q    <= sel_ch;
                        start_q <= sel_ch + ch_idx_t'(1);
                        half_q  <= '0;
                    end else begin
                        state_q <= StIdle;
                        cs_q    <= 1'b1;
                        din_q   <= 1'b0;
                    end
                end
                StFrame: begin
                    if (tick) begin
                        if (half_q == LastHalf) begin
                            state_q      <= StGap;
                            half_q       <= '0;
                            cs_q         <= 1'b1;
                            adclk_q      <= 1'b0;
                            din_q        <= 1'b0;
                            valid_q      <= 1'b1;
                            done_q       <= (ch_q == hi_ch);
                            data_q       <= sh_q;
                            sch_q        <= ch_q;
                            scan_q[ch_q] <= sh_q;
                        end else begin
                            half_q  <= nh;
                            adclk_q <= nh[0];
                            din_q   <= din_next;
                            if (sample_en) begin
                                sh_q <= {sh_q[ADC_BITS-2:0], bus.DOUT};
                            end
                        end
                    end
                end
                StGap: begin
                    if (tick) begin
                        if (half_q == LastGap) begin
                            half_q <= '0;
                            if (bus.enable && (bus.ch_mask != '0)) begin
                                state_q <= StSelect;
                                cs_q    <= 1'b0;
                                din_q   <= 1'b1;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            half_q <= nh;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.CS           = cs_q;
    assign bus.AD_CLK       = adclk_q;
    assign bus.DIN          = din_q;
    assign bus.sample_valid = valid_q;
    assign bus.scan_done    = done_q;
    assign bus.sample_data  = data_q;
    assign bus.sample_ch    = sch_q;
    assign bus.analog_scan  = scan_q;

endmodule

// File: tb/tb_mcp3008_scanner.sv
// Scoreboard bench for mcp3008_scanner with an MCP3008 behavioural model.
`timescale 1ns/1ps
module tb_mcp3008_scanner;

    localparam int FramePeriod = 925;

    typedef struct {
        logic [2:0] ch;
        logic [9:0] data;
        logic       done;
    } exp_t;

    logic clk;
    logic rst;
    logic dout;

    mcp3008_scanner_if bus();

    mcp3008_scanner #(
        .CLK_DIV      (25),
        .CS_IDLE_HALF (2),
        .SGL          (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.DOUT = dout;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_valid = 0;
    int         cyc = 0;
    int         toggle_bad = 0;
    int         last_cyc = 0;
    bit         chk_period = 0;
    bit         have_last = 0;
    logic       prev_adclk = 1'b0;
    exp_t       exp_q[$];
    logic [4:0] cmd_log[$];
    logic [9:0] ov_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] ch, input logic [9:0] data, input logic done);
        exp_t e;
        e.ch   = ch;
        e.data = data;
        e.done = done;
        exp_q.push_back(e);
    endtask

    task automatic wait_valids(input int target, input int limit);
        int t = 0;
        while (n_valid < target && t < limit) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("valid_count_in_budget", n_valid, target);
    endtask

    task automatic wait_cs_low(input int limit);
        int t = 0;
        while (bus.CS !== 1'b0 && t < limit) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("cs_fall_in_budget", {31'd0, bus.CS}, 32'd0);
    endtask

    task automatic idle_clks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
        end
        #1;
    endtask

    // MCP3008 model: command clocked in on rising edges 1..5, data out on falling edges.
    int         k_cnt = 0;
    logic [4:0] cmd = '0;
    logic [9:0] mval = '0;

    always @(posedge bus.AD_CLK or posedge bus.CS) begin
        if (bus.CS) begin
            k_cnt = 0;
        end else begin
            k_cnt = k_cnt + 1;
            if (k_cnt <= 5) cmd = {cmd[3:0], bus.DIN};
            if (k_cnt == 5) begin
                cmd_log.push_back(cmd);
                if (ov_q.size() != 0) mval = ov_q.pop_front();
                else mval = 10'h155 + {7'd0, cmd[2:0]};
            end
        end
    end

    always @(negedge bus.AD_CLK or posedge bus.CS) begin
        if (bus.CS) dout = 1'b0;
        else if (k_cnt >= 7 && k_cnt <= 16) dout = mval[16 - k_cnt];
        else dout = 1'b0;
    end

    // Monitor: pops the scoreboard on every result strobe and watches AD_CLK idling.
    always @(negedge clk) begin
        exp_t e;
        if (bus.sample_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                check("unexpected_sample_valid", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sample_ch", {29'd0, bus.sample_ch}, {29'd0, e.ch});
                check("sample_data", {22'd0, bus.sample_data}, {22'd0, e.data});
                check("scan_done", {31'd0, bus.scan_done}, {31'd0, e.done});
                check("analog_scan_entry", {22'd0, bus.analog_scan[e.ch]}, {22'd0, e.data});
            end
            if (chk_period) begin
                if (have_last) check("frame_period", cyc - last_cyc, FramePeriod);
                have_last = 1'b1;
                last_cyc  = cyc;
            end
        end else if (bus.scan_done === 1'b1) begin
            check("scan_done_without_valid", 32'd1, 32'd0);
        end
        if (rst === 1'b0) begin
            if (bus.AD_CLK !== prev_adclk && bus.CS !== 1'b0) toggle_bad++;
            if (bus.CS === 1'b1 && bus.AD_CLK !== 1'b0) toggle_bad++;
        end
        prev_adclk = bus.AD_CLK;
    end

    initial begin
        int base;
        rst         = 1'b0;
        bus.enable  = 1'b0;
        bus.ch_mask = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        check("reset_cs", {31'd0, bus.CS}, 32'd1);
        check("reset_adclk", {31'd0, bus.AD_CLK}, 32'd0);
        check("reset_din", {31'd0, bus.DIN}, 32'd0);
        check("reset_valid", {31'd0, bus.sample_valid}, 32'd0);
        check("reset_data", {22'd0, bus.sample_data}, 32'd0);
        idle_clks(4);
        rst = 1'b0;
        idle_clks(2);

        // Full mask: channels 0..7 in order, one frame period apart.
        for (int i = 0; i < 8; i++) push_exp(3'(i), 10'h155 + 10'(i), (i == 7));
        chk_period  = 1'b1;
        have_last   = 1'b0;
        base        = n_valid;
        bus.ch_mask = 8'hFF;
        bus.enable  = 1'b1;
        wait_valids(base + 8, 8 * FramePeriod + 500);
        bus.enable = 1'b0;
        chk_period = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("analog_scan_bank", {22'd0, bus.analog_scan[i]}, 32'h155 + i);
        end
        idle_clks(100);

        // Two-channel mask: 5,7,5,7 and the command words on DIN.
        cmd_log.delete();
        push_exp(3'd5, 10'h15A, 1'b0);
        push_exp(3'd7, 10'h15C, 1'b1);
        push_exp(3'd5, 10'h15A, 1'b0);
        push_exp(3'd7, 10'h15C, 1'b1);
        base        = n_valid;
        bus.ch_mask = 8'hA0;
        bus.enable  = 1'b1;
        wait_valids(base + 4, 4 * FramePeriod + 500);
        bus.enable = 1'b0;
        check("cmd_log_size", cmd_log.size(), 4);
        if (cmd_log.size() >= 2) begin
            check("din_cmd_ch5", {27'd0, cmd_log[0]}, 32'b11101);
            check("din_cmd_ch7", {27'd0, cmd_log[1]}, 32'b11111);
        end
        idle_clks(100);

        // Single channel, full-scale then zero.
        ov_q.push_back(10'h3FF);
        ov_q.push_back(10'h000);
        push_exp(3'd3, 10'h3FF, 1'b1);
        push_exp(3'd3, 10'h000, 1'b1);
        base        = n_valid;
        bus.ch_mask = 8'h08;
        bus.enable  = 1'b1;
        wait_valids(base + 2, 2 * FramePeriod + 500);
        bus.enable = 1'b0;
        idle_clks(100);

        // Mask change mid-frame: ch 4 completes, then ch 1.
        push_exp(3'd4, 10'h159, 1'b0);
        push_exp(3'd1, 10'h156, 1'b1);
        base        = n_valid;
        bus.ch_mask = 8'hFF;
        bus.enable  = 1'b1;
        wait_cs_low(200);
        idle_clks(300);
        bus.ch_mask = 8'h02;
        wait_valids(base + 2, 2 * FramePeriod + 500);
        bus.enable = 1'b0;
        idle_clks(100);

        // Reset at half 20: asynchronous outputs, aborted frame, restart at ch 0.
        base        = n_valid;
        bus.ch_mask = 8'hFF;
        bus.enable  = 1'b1;
        wait_cs_low(200);
        idle_clks(500);
        rst = 1'b1;
        #1;
        check("async_rst_cs", {31'd0, bus.CS}, 32'd1);
        check("async_rst_adclk", {31'd0, bus.AD_CLK}, 32'd0);
        check("async_rst_din", {31'd0, bus.DIN}, 32'd0);
        check("async_rst_valid", {31'd0, bus.sample_valid}, 32'd0);
        check("async_rst_done", {31'd0, bus.scan_done}, 32'd0);
        check("async_rst_ch", {29'd0, bus.sample_ch}, 32'd0);
        check("async_rst_bank_clear", {31'd0, (bus.analog_scan == '0)}, 32'd1);
        idle_clks(4);
        push_exp(3'd0, 10'h155, 1'b0);
        rst = 1'b0;
        wait_valids(base + 1, 2 * FramePeriod + 500);
        bus.enable = 1'b0;
        idle_clks(100);

        // Enable drops at half 10: frame finishes, then idle.
        push_exp(3'd1, 10'h156, 1'b0);
        base        = n_valid;
        bus.ch_mask = 8'hFF;
        bus.enable  = 1'b1;
        wait_cs_low(200);
        idle_clks(250);
        bus.enable = 1'b0;
        wait_valids(base + 1, 2 * FramePeriod);
        idle_clks(1000);
        check("idle_after_disable_count", n_valid, base + 1);
        check("idle_after_disable_cs", {31'd0, bus.CS}, 32'd1);

        // Empty mask with enable held: no frames.
        base        = n_valid;
        bus.ch_mask = 8'h00;
        bus.enable  = 1'b1;
        idle_clks(1000);
        check("empty_mask_count", n_valid, base);
        check("empty_mask_cs", {31'd0, bus.CS}, 32'd1);
        bus.enable = 1'b0;

        check("adclk_only_with_cs_low", toggle_bad, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
